imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
  MEM_DEPTH  2048  instruction memory depth in 32-bit words.
  ADDR_W  12  word-address width of the write port.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk_sys  in  1  single system clock.
  rst_n  in  1  asynchronous active-low reset.
  i_start  in  1  one-cycle pulse that begins a load.
  i_byte_valid  in  1  input byte valid.
  i_byte  in  8  input byte.
  o_byte_ready  out  1  loader accepts a byte.
  o_instr_wena  out  1  imem write enable.
  o_instr_waddra  out  ADDR_W  imem word write address.
  o_instr_dina  out  32  imem write data.
  o_core_rst  out  1  hold core in reset, active-high.
  o_done  out  1  load completed successfully.
  o_err  out  1  load aborted.
REQ-003 The block SHALL use one clock (clk_sys), and reset (rst_n) SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL accept a byte only on a cycle where i_byte_valid and o_byte_ready are both 1.
REQ-005 The stream SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, little-endian.
REQ-006 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-007 The FSM SHALL transition as follows:
  IDLE->LEN_LO on i_start.
  LEN_LO->LEN_HI on a byte.
  LEN_HI->DATA on a byte when 0<N<=MEM_DEPTH.
  LEN_HI->DONE on a byte when N==0.
  LEN_HI->ERR on a byte when N>MEM_DEPTH.
  DATA->WRITE on the 4th byte of a word.
  WRITE->DATA if words remain, else WRITE->DONE.
  DONE->LEN_LO on i_start.
  ERR->LEN_LO on i_start.
REQ-008 o_byte_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA.
REQ-009 In WRITE, o_instr_wena SHALL be 1 for exactly one cycle, with o_instr_dina equal to the assembled word and o_instr_waddra equal to the word index (starting at 0, incrementing by 1).
REQ-010 Write latency SHALL be one cycle: the wena cycle immediately follows the 4th accepted byte.
REQ-011 The word index SHALL not wrap, because N<=MEM_DEPTH is enforced before any write.
REQ-012 o_core_rst SHALL be 1 in every state except DONE; in DONE it SHALL be 0.
REQ-013 o_done SHALL be 1 only in DONE, and o_err SHALL be 1 only in ERR.
REQ-014 i_start asserted in LEN_LO, LEN_HI, DATA or WRITE SHALL restart the load: go to LEN_LO, clear the index and byte counters, and not write the partial word.
REQ-015 If i_start and a byte handshake occur in the same cycle, i_start SHALL take priority and the byte SHALL be dropped.
REQ-016 Gaps in i_byte_valid SHALL stall the FSM without any effect on state.

Reset
REQ-017 While rst_n is 0, the block SHALL be in IDLE with all counters at 0 and outputs o_byte_ready=0, o_instr_wena=0, o_instr_waddra=0, o_instr_dina=0, o_core_rst=1, o_done=0 and o_err=0.
REQ-018 Reset asserted mid-load SHALL abort the load immediately, with no further writes after rst_n deasserts.

Configuration
REQ-019 With IMEM_LOADER_CKSUM_EN defined, one checksum byte SHALL follow the last data word, in a CKSUM state with o_byte_ready=1.
REQ-020 With IMEM_LOADER_CKSUM_EN defined, the checksum SHALL be the XOR of all data bytes; a match SHALL go to DONE and a mismatch to ERR.
REQ-021 With IMEM_LOADER_CKSUM_EN defined and N==0, the checksum byte SHALL still be consumed and compared against 0x00.
REQ-022 Without IMEM_LOADER_CKSUM_EN, the CKSUM state and the XOR register SHALL not exist, and the FSM SHALL behave as in REQ-007.

Structure
REQ-023 A shared package SHALL hold the FSM state enumeration and the stream-format constants (header byte count 2, bytes-per-word 4).
REQ-024 The block SHALL be a single module with no sub-module; the byte-to-word assembler SHALL be inline shift-register logic.

Verification
REQ-025 The bench SHALL cover the basic load: start; bytes 02 00, 13 00 00 00, 93 00 10 00 -> writes (0, 0x00000013) and (1, 0x00100093); then o_done=1 and o_core_rst=0.
REQ-026 The bench SHALL cover oversize: header 01 08 (N=2049) -> o_err=1, no o_instr_wena, o_core_rst=1.
REQ-027 The bench SHALL cover restart: i_start after 6 data bytes of an N=2 load -> no write occurs for the partial word, and a new load beginning 01 00 writes address 0.
REQ-028 The bench SHALL cover stalls: random i_byte_valid gaps during an N=3 load -> identical writes to the gap-free run, with each wena one cycle after that word's 4th accepted byte.
REQ-029 The bench SHALL cover the checksum with IMEM_LOADER_CKSUM_EN defined: N=1, word 11 22 33 44, checksum 0x44 -> o_done=1; checksum 0x45 -> o_err=1.
REQ-030 The bench SHALL cover reset mid-load: rst_n low during DATA -> all outputs at their REQ-017 values and no write after release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
// IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte and its CKSUM state.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = HDR_BYTES * 8;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
`ifdef IMEM_LOADER_CKSUM_EN
        ST_ERR,
        ST_CKSUM
`else
        ST_ERR
`endif
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader: header gives word count N, then N little-endian words are written to imem.
// Optional feature: define IMEM_LOADER_CKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_W    = 12
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_instr_wena,
    output logic [ADDR_W-1:0] o_instr_waddra,
    output logic [31:0]       o_instr_dina,
    output logic              o_core_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [31:0] DEPTH_U  = 32'(MEM_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [31:0]         word_q, word_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic                hs;
    logic [LEN_W-1:0]    len_hdr;
    logic                more_words;

    assign hs         = i_byte_valid & o_byte_ready;
    assign len_hdr    = {i_byte, len_lo_q};
    // Compare in 32 bits so the last index never has to be represented past MEM_DEPTH-1.
    assign more_words = (32'(idx_q) + 32'd1) < 32'(len_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    // Next state: i_start overrides everything, including a same-cycle byte.
    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = ST_LEN_LO;
        end else begin
            case (state_q)
                ST_LEN_LO: if (hs) state_d = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (hs) begin
                        if (len_hdr == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_d = ST_CKSUM;
`else
                            state_d = ST_DONE;
`endif
                        end else if (32'(len_hdr) > DEPTH_U) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: if (hs && bcnt_q == LAST_BYTE) state_d = ST_WRITE;
                ST_WRITE: begin
                    if (more_words) begin
                        state_d = ST_DATA;
                    end else begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                ST_CKSUM: if (hs) state_d = (i_byte == xor_q) ? ST_DONE : ST_ERR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: header capture, little-endian word assembly, word index.
    always_comb begin
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_d    = xor_q;
`endif
        if (i_start) begin
            len_lo_d = '0;
            len_d    = '0;
            idx_d    = '0;
            bcnt_d   = '0;
            word_d   = '0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_LEN_LO: if (hs) len_lo_d = i_byte;
                ST_LEN_HI: if (hs) len_d = len_hdr;
                ST_DATA: begin
                    if (hs) begin
                        // First byte received ends up in bits [7:0].
                        word_d = {i_byte, word_q[31:8]};
                        bcnt_d = (bcnt_q == LAST_BYTE) ? '0 : bcnt_q + 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                        xor_d  = xor_q ^ i_byte;
`endif
                    end
                end
                ST_WRITE: if (more_words) idx_d = idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_instr_wena = 1'b0;
        o_core_rst   = 1'b1;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (state_q)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: o_byte_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: o_byte_ready = 1'b1;
`endif
            ST_WRITE: o_instr_wena = 1'b1;
            ST_DONE: begin
                o_core_rst = 1'b0;
                o_done     = 1'b1;
            end
            ST_ERR:  o_err = 1'b1;
            default: ;
        endcase
    end

    assign o_instr_waddra = idx_q;
    assign o_instr_dina   = word_q;

endmodule
